// File: rtl/core_ctrl_fsm_if.sv
// Control/handshake bundle between the core control sequencer and the
// datapath/memory side: IR contents, memory handshake, datapath strobes,
// mux selects, trap flag and the visible state code.
interface core_ctrl_fsm_if;
   logic [31:0] instr;
   logic        mem_ready;
   logic        branch_taken;
   logic        mem_req;
   logic        mem_we;
   logic        mem_sel;
   logic        ir_load;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        alu_src_a;
   logic        alu_src_b;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic        trap;
   logic [2:0]  state;

   // Sequencer side: reads IR and handshake, drives strobes and selects
   modport master (
      input  instr, mem_ready, branch_taken,
      output mem_req, mem_we, mem_sel, ir_load, pc_write, pc_src,
             alu_src_a, alu_src_b, rf_we, wb_sel, trap, state
   );

   // Datapath/memory side
   modport slave (
      output instr, mem_ready, branch_taken,
      input  mem_req, mem_we, mem_sel, ir_load, pc_write, pc_src,
             alu_src_a, alu_src_b, rf_we, wb_sel, trap, state
   );
endinterface

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes and mux selects from the
// IR opcode, runs the shared memory handshake and traps on illegal opcodes or
// on a memory request that waits MEM_TIMEOUT cycles without mem_ready.
module core_ctrl_fsm #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input logic             clk,
   input logic             rst_n,
   core_ctrl_fsm_if.master ctrl
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      BOOT   = 3'd5,
      TRAP   = 3'd7
   } state_t;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;

   localparam int unsigned   CW        = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

   state_t        st;
   logic [CW-1:0] wait_cnt;
   logic          trap_q;

   logic [6:0] op;
   logic       is_r, is_i, is_load, is_store, is_branch;
   logic       is_jal, is_jalr, is_lui, is_auipc, is_legal;
   logic       unused_instr_bits;

   // Opcode classification from the IR
   always_comb begin
      op                = ctrl.instr[6:0];
      is_r              = (op == OP_R);
      is_i              = (op == OP_I);
      is_load           = (op == OP_LOAD);
      is_store          = (op == OP_STORE);
      is_branch         = (op == OP_BRANCH);
      is_jal            = (op == OP_JAL);
      is_jalr           = (op == OP_JALR);
      is_lui            = (op == OP_LUI);
      is_auipc          = (op == OP_AUIPC);
      is_legal          = is_r | is_i | is_load | is_store | is_branch |
                          is_jal | is_jalr | is_lui | is_auipc;
      unused_instr_bits = ^ctrl.instr[31:7];
   end

   // State register, memory wait counter and sticky trap flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= BOOT;
         wait_cnt <= '0;
         trap_q   <= 1'b0;
      end else begin
         case (st)
            BOOT: begin
               st       <= FETCH;
               wait_cnt <= '0;
            end
            FETCH, MEM: begin
               // mem_ready in the last permitted wait cycle still wins over the timeout
               if (ctrl.mem_ready) begin
                  wait_cnt <= '0;
                  if (st == FETCH)
                     st <= DECODE;
                  else if (is_load)
                     st <= WB;
                  else
                     st <= FETCH;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1'b1);
                  if (wait_cnt == LAST_WAIT) begin
                     st     <= TRAP;
                     trap_q <= 1'b1;
                  end
               end
            end
            DECODE: begin
               if (is_legal) begin
                  st <= EXEC;
               end else begin
                  st     <= TRAP;
                  trap_q <= 1'b1;
               end
            end
            EXEC: begin
               wait_cnt <= '0;
               if (is_load || is_store)
                  st <= MEM;
               else if (is_branch)
                  st <= FETCH;
               else
                  st <= WB;
            end
            WB: begin
               st       <= FETCH;
               wait_cnt <= '0;
            end
            TRAP: begin
               st     <= TRAP;
               trap_q <= 1'b1;
            end
            default: begin
               st     <= TRAP;
               trap_q <= 1'b1;
            end
         endcase
      end
   end

   // Strobes and selects decoded from state, opcode and mem_ready
   always_comb begin
      ctrl.mem_req   = 1'b0;
      ctrl.mem_we    = 1'b0;
      ctrl.mem_sel   = 1'b0;
      ctrl.ir_load   = 1'b0;
      ctrl.pc_write  = 1'b0;
      ctrl.pc_src    = 2'd0;
      ctrl.alu_src_a = 1'b0;
      ctrl.alu_src_b = 1'b0;
      ctrl.rf_we     = 1'b0;
      ctrl.wb_sel    = 2'd0;
      ctrl.trap      = trap_q;
      ctrl.state     = st;
      case (st)
         FETCH: begin
            ctrl.mem_req = 1'b1;
            ctrl.ir_load = ctrl.mem_ready;
         end
         EXEC: begin
            ctrl.alu_src_a = is_auipc;
            ctrl.alu_src_b = is_i | is_load | is_store | is_jalr | is_auipc;
            if (is_branch) begin
               ctrl.pc_write = 1'b1;
               ctrl.pc_src   = ctrl.branch_taken ? 2'd1 : 2'd0;
            end
         end
         MEM: begin
            ctrl.mem_req   = 1'b1;
            ctrl.mem_sel   = 1'b1;
            ctrl.mem_we    = is_store;
            ctrl.alu_src_a = is_auipc;
            ctrl.alu_src_b = is_i | is_load | is_store | is_jalr | is_auipc;
            if (ctrl.mem_ready && is_store)
               ctrl.pc_write = 1'b1;
         end
         WB: begin
            ctrl.rf_we    = 1'b1;
            ctrl.pc_write = 1'b1;
            if (is_load)
               ctrl.wb_sel = 2'd1;
            else if (is_jal || is_jalr)
               ctrl.wb_sel = 2'd2;
            else if (is_lui)
               ctrl.wb_sel = 2'd3;
            if (is_jal)
               ctrl.pc_src = 2'd1;
            else if (is_jalr)
               ctrl.pc_src = 2'd2;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Bench for core_ctrl_fsm: directed vector table, hand-written trap/timeout/
// reset sequences, then random instructions against a per-instruction
// reference model that expands each instruction into its expected cycle trace.
module tb_core_ctrl_fsm;

   localparam int unsigned TMO = 4;

   localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_X = 3'd2, S_M = 3'd3,
                          S_W = 3'd4, S_B = 3'd5, S_T = 3'd7;

   localparam logic [31:0] ADDI  = 32'h00500093;
   localparam logic [31:0] LW    = 32'h0000A103;
   localparam logic [31:0] SW    = 32'h0020A023;
   localparam logic [31:0] BEQ   = 32'h00208463;
   localparam logic [31:0] JAL   = 32'h008000EF;
   localparam logic [31:0] JALR  = 32'h000080E7;
   localparam logic [31:0] LUI   = 32'h123450B7;
   localparam logic [31:0] AUIPC = 32'h00001097;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   core_ctrl_fsm_if bus_if ();

   core_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (bus_if)
   );

   typedef struct packed {
      logic [2:0] st;
      logic       req;
      logic       we;
      logic       sel;
      logic       irl;
      logic       pcw;
      logic [1:0] pcs;
      logic       sa;
      logic       sb;
      logic       rfwe;
      logic [1:0] wbs;
      logic       trp;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic        rdy;
      logic        tk;
      exp_t        e;
   } vec_t;

   typedef struct {
      logic rdy;
      logic tk;
      exp_t e;
   } cyc_t;

   int   errors = 0;
   int   checks = 0;
   vec_t tbl[$];
   cyc_t q[$];

   function automatic exp_t mk(input logic [2:0] st, input logic req, input logic we,
                               input logic sel, input logic irl, input logic pcw,
                               input logic [1:0] pcs, input logic sa, input logic sb,
                               input logic rfwe, input logic [1:0] wbs, input logic trp);
      exp_t e;
      e.st = st; e.req = req; e.we = we; e.sel = sel; e.irl = irl; e.pcw = pcw;
      e.pcs = pcs; e.sa = sa; e.sb = sb; e.rfwe = rfwe; e.wbs = wbs; e.trp = trp;
      return e;
   endfunction

   function automatic exp_t actual();
      exp_t a;
      a.st = bus_if.state; a.req = bus_if.mem_req; a.we = bus_if.mem_we;
      a.sel = bus_if.mem_sel; a.irl = bus_if.ir_load; a.pcw = bus_if.pc_write;
      a.pcs = bus_if.pc_src; a.sa = bus_if.alu_src_a; a.sb = bus_if.alu_src_b;
      a.rfwe = bus_if.rf_we; a.wbs = bus_if.wb_sel; a.trp = bus_if.trap;
      return a;
   endfunction

   function automatic void addv(input logic [31:0] ins, input logic rdy, input logic tk,
                                input exp_t e);
      vec_t v;
      v.instr = ins; v.rdy = rdy; v.tk = tk; v.e = e;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input exp_t e);
      exp_t a;
      a = actual();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                  name, a, a.st, e, e.st);
      end
   endtask

   // Inputs applied at posedge+1, outputs sampled at the falling edge
   task automatic step(input logic rdy, input logic tk, input exp_t e, input string name);
      bus_if.mem_ready    = rdy;
      bus_if.branch_taken = tk;
      #4;
      check(name, e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string name);
      rst_n = 1'b0;
      #1;
      check(name, mk(S_B, 0,0,0,0,0,2'd0,0,0,0,2'd0,0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Reference model: expands one instruction into its expected cycle trace
   function automatic void push_cyc(input logic rdy, input logic tk, input exp_t e);
      cyc_t c;
      c.rdy = rdy; c.tk = tk; c.e = e;
      q.push_back(c);
   endfunction

   function automatic void push_trap();
      for (int i = 0; i < 3; i++)
         push_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  mk(S_T, 0,0,0,0,0,2'd0,0,0,0,2'd0,1));
   endfunction

   function automatic void model_instr(input logic [31:0] ins, input int unsigned wf,
                                       input int unsigned wm, output bit trapped);
      logic [6:0] op;
      bit         legal, ld, stv, br, sa, sb;
      logic [1:0] wbs, pcs;
      logic       tk;
      op      = ins[6:0];
      legal   = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      ld      = (op == 7'h03);
      stv     = (op == 7'h23);
      br      = (op == 7'h63);
      sa      = (op == 7'h17);
      sb      = op inside {7'h13, 7'h03, 7'h23, 7'h67, 7'h17};
      wbs     = ld ? 2'd1 : (op == 7'h6F || op == 7'h67) ? 2'd2 : (op == 7'h37) ? 2'd3 : 2'd0;
      pcs     = (op == 7'h6F) ? 2'd1 : (op == 7'h67) ? 2'd2 : 2'd0;
      trapped = 1'b0;
      // fetch: ready on wait index wf, or TMO waiting cycles then trap
      for (int unsigned k = 0; k < TMO; k++) begin
         push_cyc(k == wf, 1'($urandom_range(0, 1)),
                  mk(S_F, 1,0,0, (k == wf), 0,2'd0,0,0,0,2'd0,0));
         if (k == wf) break;
      end
      if (wf >= TMO) begin trapped = 1'b1; push_trap(); return; end
      push_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               mk(S_D, 0,0,0,0,0,2'd0,0,0,0,2'd0,0));
      if (!legal) begin trapped = 1'b1; push_trap(); return; end
      tk = 1'($urandom_range(0, 1));
      push_cyc(1'($urandom_range(0, 1)), tk,
               mk(S_X, 0,0,0,0, br, br ? {1'b0, tk} : 2'd0, sa, sb, 0, 2'd0, 0));
      if (br) return;
      if (ld || stv) begin
         for (int unsigned k = 0; k < TMO; k++) begin
            push_cyc(k == wm, 1'($urandom_range(0, 1)),
                     mk(S_M, 1, stv, 1, 0, stv && (k == wm), 2'd0, sa, sb, 0, 2'd0, 0));
            if (k == wm) break;
         end
         if (wm >= TMO) begin trapped = 1'b1; push_trap(); return; end
         if (stv) return;
      end
      push_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               mk(S_W, 0,0,0,0,1, pcs, 0,0,1, wbs, 0));
   endfunction

   function automatic int unsigned rand_wait();
      if ($urandom_range(0, 11) == 0)
         return TMO + $urandom_range(0, 2);
      return $urandom_range(0, TMO - 1);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] legal_ops [9];
      logic [6:0]  bad_ops   [4];
      logic [31:0] ins;
      bit          trapped;
      exp_t        e_b, e_d, e_t;

      legal_ops = '{ADDI, 32'h002081B3, LW, SW, BEQ, JAL, JALR, LUI, AUIPC};
      bad_ops   = '{7'h7F, 7'h00, 7'h0F, 7'h73};
      e_b = mk(S_B, 0,0,0,0,0,2'd0,0,0,0,2'd0,0);
      e_d = mk(S_D, 0,0,0,0,0,2'd0,0,0,0,2'd0,0);
      e_t = mk(S_T, 0,0,0,0,0,2'd0,0,0,0,2'd0,1);

      // ADDI with ready on the 3rd fetch cycle
      addv(ADDI, 0,0, e_b);
      addv(ADDI, 0,0, mk(S_F, 1,0,0,0,0,2'd0,0,0,0,2'd0,0));
      addv(ADDI, 0,0, mk(S_F, 1,0,0,0,0,2'd0,0,0,0,2'd0,0));
      addv(ADDI, 1,0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0));
      addv(ADDI, 1,0, e_d);
      addv(ADDI, 1,0, mk(S_X, 0,0,0,0,0,2'd0,0,1,0,2'd0,0));
      addv(ADDI, 0,0, mk(S_W, 0,0,0,0,1,2'd0,0,0,1,2'd0,0));
      // LW with one memory wait
      addv(LW, 1,0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0));
      addv(LW, 0,0, e_d);
      addv(LW, 0,0, mk(S_X, 0,0,0,0,0,2'd0,0,1,0,2'd0,0));
      addv(LW, 0,0, mk(S_M, 1,0,1,0,0,2'd0,0,1,0,2'd0,0));
      addv(LW, 1,0, mk(S_M, 1,0,1,0,0,2'd0,0,1,0,2'd0,0));
      addv(LW, 0,0, mk(S_W, 0,0,0,0,1,2'd0,0,0,1,2'd1,0));
      // SW
      addv(SW, 1,0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0));
      addv(SW, 0,0, e_d);
      addv(SW, 0,1, mk(S_X, 0,0,0,0,0,2'd0,0,1,0,2'd0,0));
      addv(SW, 1,0, mk(S_M, 1,1,1,0,1,2'd0,0,1,0,2'd0,0));
      // BEQ taken, then not taken
      addv(BEQ, 1,0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0));
      addv(BEQ, 0,0, e_d);
      addv(BEQ, 1,1, mk(S_X, 0,0,0,0,1,2'd1,0,0,0,2'd0,0));
      addv(BEQ, 1,0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0));
      addv(BEQ, 0,1, e_d);
      addv(BEQ, 0,0, mk(S_X, 0,0,0,0,1,2'd0,0,0,0,2'd0,0));
      // JAL, JALR, LUI, AUIPC
      addv(JAL, 1,0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0));
      addv(JAL, 0,0, e_d);
      addv(JAL, 0,0, mk(S_X, 0,0,0,0,0,2'd0,0,0,0,2'd0,0));
      addv(JAL, 0,0, mk(S_W, 0,0,0,0,1,2'd1,0,0,1,2'd2,0));
      addv(JALR, 1,0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0));
      addv(JALR, 0,0, e_d);
      addv(JALR, 0,0, mk(S_X, 0,0,0,0,0,2'd0,0,1,0,2'd0,0));
      addv(JALR, 0,0, mk(S_W, 0,0,0,0,1,2'd2,0,0,1,2'd2,0));
      addv(LUI, 1,0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0));
      addv(LUI, 0,0, e_d);
      addv(LUI, 0,0, mk(S_X, 0,0,0,0,0,2'd0,0,0,0,2'd0,0));
      addv(LUI, 0,0, mk(S_W, 0,0,0,0,1,2'd0,0,0,1,2'd3,0));
      addv(AUIPC, 1,0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0));
      addv(AUIPC, 0,0, e_d);
      addv(AUIPC, 0,0, mk(S_X, 0,0,0,0,0,2'd0,1,1,0,2'd0,0));
      addv(AUIPC, 0,0, mk(S_W, 0,0,0,0,1,2'd0,0,0,1,2'd0,0));

      bus_if.instr        = '0;
      bus_if.mem_ready    = 1'b0;
      bus_if.branch_taken = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 check("reset state", e_b);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (tbl[i]) begin
         bus_if.instr = tbl[i].instr;
         step(tbl[i].rdy, tbl[i].tk, tbl[i].e, $sformatf("vec[%0d]", i));
      end

      // Illegal opcode traps and holds with no memory request
      bus_if.instr = 32'hFFFFFFFF;
      step(1, 0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0), "illegal fetch");
      step(0, 0, e_d, "illegal decode");
      for (int i = 0; i < 20; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e_t, $sformatf("trap hold %0d", i));
      do_reset("reset from trap");
      step(0, 0, e_b, "boot after trap");

      // Fetch timeout after exactly TMO request cycles
      bus_if.instr = ADDI;
      for (int unsigned k = 0; k < TMO; k++)
         step(0, 0, mk(S_F, 1,0,0,0,0,2'd0,0,0,0,2'd0,0), $sformatf("timeout fetch %0d", k));
      step(0, 0, e_t, "timeout trap");
      do_reset("reset from timeout");
      step(0, 0, e_b, "boot after timeout");

      // Ready in the last permitted cycle wins
      for (int unsigned k = 0; k < TMO - 1; k++)
         step(0, 0, mk(S_F, 1,0,0,0,0,2'd0,0,0,0,2'd0,0), $sformatf("late fetch %0d", k));
      step(1, 0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0), "late fetch ready");
      step(0, 0, e_d, "late decode");
      step(0, 0, mk(S_X, 0,0,0,0,0,2'd0,0,1,0,2'd0,0), "late exec");
      step(0, 0, mk(S_W, 0,0,0,0,1,2'd0,0,0,1,2'd0,0), "late wb");

      // Reset while a load is waiting in MEM
      bus_if.instr = LW;
      step(1, 0, mk(S_F, 1,0,0,1,0,2'd0,0,0,0,2'd0,0), "midmem fetch");
      step(0, 0, e_d, "midmem decode");
      step(0, 0, mk(S_X, 0,0,0,0,0,2'd0,0,1,0,2'd0,0), "midmem exec");
      bus_if.mem_ready = 1'b0;
      #4 check("midmem request", mk(S_M, 1,0,1,0,0,2'd0,0,1,0,2'd0,0));
      do_reset("midmem reset drops request");
      step(0, 0, e_b, "boot after midmem reset");

      // Random instructions against the reference model
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 11) == 0)
            ins = {$urandom_range(0, 32'h01FFFFFF) & 32'h01FFFFFF, 7'h00} |
                  {25'd0, bad_ops[$urandom_range(0, 3)]};
         else
            ins = (legal_ops[$urandom_range(0, 8)] & 32'h0000007F) |
                  ($urandom & 32'hFFFFFF80);
         q.delete();
         model_instr(ins, rand_wait(), rand_wait(), trapped);
         bus_if.instr = ins;
         foreach (q[k])
            step(q[k].rdy, q[k].tk, q[k].e, $sformatf("rand i%0d c%0d op %h", n, k, ins[6:0]));
         if (trapped) begin
            do_reset($sformatf("rand reset i%0d", n));
            step(0, 0, e_b, $sformatf("rand boot i%0d", n));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
